// File: rtl/chip8_fb_scanout.sv
// Framebuffer scan-out: snapshots the 2048-bit display and streams it one pixel per beat over valid/ready.
// Optional CHIP8_SCANOUT_DOUBLE_EN: 2x pixel doubling (each pixel twice, each row twice).
module chip8_fb_scanout #(
  parameter int unsigned FB_W = 64,
  parameter int unsigned FB_H = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FB_W*FB_H-1:0] display,
  input  logic                 frame_req,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_data,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 pix_eof,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned NPIX = FB_W * FB_H;
  localparam int unsigned IW   = $clog2(NPIX);
  localparam int unsigned XW   = $clog2(FB_W);
  localparam int unsigned YW   = $clog2(FB_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NPIX-1:0]   shadow_q, shadow_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              pending_q, pending_d;
`ifdef CHIP8_SCANOUT_DOUBLE_EN
  logic              xs_q, xs_d;
  logic              ys_q, ys_d;
`endif

  logic [IW-1:0]     idx;
  logic              last_x, last_y, first_beat, row_end, frame_end, beat;

  always_comb begin
    last_x = (x_q == XW'(FB_W - 1));
    last_y = (y_q == YW'(FB_H - 1));
`ifdef CHIP8_SCANOUT_DOUBLE_EN
    // Output raster position is {x,xs} horizontally and {y,ys} vertically.
    first_beat = (x_q == '0) && (y_q == '0) && !xs_q && !ys_q;
    row_end    = last_x && xs_q;
    frame_end  = row_end && last_y && ys_q;
`else
    first_beat = (x_q == '0) && (y_q == '0);
    row_end    = last_x;
    frame_end  = row_end && last_y;
`endif
    idx        = IW'(y_q) * IW'(FB_W) + IW'(x_q);
    pix_valid  = (state_q == S_STREAM);
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    pix_data   = pix_valid && shadow_q[idx];
    pix_sof    = pix_valid && first_beat;
    pix_eol    = pix_valid && row_end;
    pix_eof    = pix_valid && frame_end;
    beat       = pix_valid && pix_ready;
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    x_d       = x_q;
    y_d       = y_q;
    pending_d = pending_q;
`ifdef CHIP8_SCANOUT_DOUBLE_EN
    xs_d      = xs_q;
    ys_d      = ys_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_req || pending_q) begin
          shadow_d  = display;
          x_d       = '0;
          y_d       = '0;
          pending_d = 1'b0;
          state_d   = S_STREAM;
`ifdef CHIP8_SCANOUT_DOUBLE_EN
          xs_d      = 1'b0;
          ys_d      = 1'b0;
`endif
        end
      end
      S_STREAM: begin
        if (frame_req) pending_d = 1'b1;
        if (beat) begin
          // Counters freeze on the eof beat so they never run past the frame.
          if (frame_end) begin
            state_d = S_DONE;
          end else begin
`ifdef CHIP8_SCANOUT_DOUBLE_EN
            if (!xs_q) begin
              xs_d = 1'b1;
            end else begin
              xs_d = 1'b0;
              if (!last_x) begin
                x_d = x_q + XW'(1);
              end else begin
                x_d = '0;
                if (!ys_q) begin
                  ys_d = 1'b1;
                end else begin
                  ys_d = 1'b0;
                  y_d  = y_q + YW'(1);
                end
              end
            end
`else
            if (last_x) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
`endif
          end
        end
      end
      S_DONE: begin
        if (frame_req) pending_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pending_q <= 1'b0;
`ifdef CHIP8_SCANOUT_DOUBLE_EN
      xs_q      <= 1'b0;
      ys_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pending_q <= pending_d;
`ifdef CHIP8_SCANOUT_DOUBLE_EN
      xs_q      <= xs_d;
      ys_q      <= ys_d;
`endif
    end
  end

endmodule

// File: tb/tb_chip8_fb_scanout.sv
// Randomized self-checking bench for chip8_fb_scanout against a raster reference model.
module tb_chip8_fb_scanout;

  localparam int unsigned FB_W    = 64;
  localparam int unsigned FB_H    = 32;
  localparam int unsigned FB_BITS = FB_W * FB_H;
`ifdef CHIP8_SCANOUT_DOUBLE_EN
  localparam int unsigned SC = 2;
`else
  localparam int unsigned SC = 1;
`endif
  localparam int unsigned OW     = FB_W * SC;
  localparam int unsigned NBEATS = FB_BITS * SC * SC;
  localparam int unsigned LIMIT  = NBEATS * 8 + 100;

  logic               clk = 1'b0;
  logic               reset;
  logic [FB_BITS-1:0] display;
  logic               frame_req;
  logic               pix_valid, pix_ready, pix_data, pix_sof, pix_eol, pix_eof;
  logic               busy, frame_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  chip8_fb_scanout #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk       (clk),
    .reset     (reset),
    .display   (display),
    .frame_req (frame_req),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Output beat k maps to raster position (k mod OW, k div OW), scaled back to a source pixel.
  function automatic logic exp_bit(input logic [FB_BITS-1:0] s, input int unsigned k);
    int unsigned ox, oy;
    ox = k % OW;
    oy = k / OW;
    return s[(oy / SC) * FB_W + ox / SC];
  endfunction

  function automatic logic [FB_BITS-1:0] rand_fb();
    logic [FB_BITS-1:0] v;
    for (int i = 0; i < FB_BITS / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic start_frame();
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic stream_frame(input logic [FB_BITS-1:0] snap, input int unsigned rdy_pct,
                              input bit flip, input bit extra_reqs);
    int unsigned k;
    int unsigned cyc;
    bit          stall;
    logic [3:0]  prev, cur;
    k = 0; cyc = 0; stall = 1'b0; prev = '0;
    while (k < NBEATS && cyc < LIMIT) begin
      cur = {pix_data, pix_sof, pix_eol, pix_eof};
      check("valid", 32'(pix_valid), 32'd1);
      if (!pix_valid) break;
      check("busy", 32'(busy), 32'd1);
      check("done_early", 32'(frame_done), 32'd0);
      check("data", 32'(pix_data), 32'(exp_bit(snap, k)));
      check("sof", 32'(pix_sof), 32'(k == 0));
      check("eol", 32'(pix_eol), 32'((k % OW) == OW - 1));
      check("eof", 32'(pix_eof), 32'(k == NBEATS - 1));
      if (stall) check("hold", 32'(cur), 32'(prev));
      pix_ready = ($urandom_range(99) < rdy_pct);
      frame_req = extra_reqs && (cyc == 20 || cyc == 40 || cyc == 60);
      if (flip && cyc == 10) display = ~display;
      stall = !pix_ready;
      prev  = cur;
      @(posedge clk); #1;
      if (pix_ready) k++;
      cyc++;
    end
    pix_ready = 1'b0;
    frame_req = 1'b0;
    check("beats", k, NBEATS);
  endtask

  task automatic end_frame();
    check("done_pulse", 32'(frame_done), 32'd1);
    check("valid_after_eof", 32'(pix_valid), 32'd0);
    @(posedge clk); #1;
    check("done_once", 32'(frame_done), 32'd0);
    check("idle_valid", 32'(pix_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FB_BITS-1:0] snap;
    reset = 1'b0; frame_req = 1'b0; pix_ready = 1'b0; display = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_outs", 32'({pix_valid, busy, frame_done, pix_sof, pix_eol, pix_eof, pix_data}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_idle", 32'({pix_valid, busy}), 32'd0);

    // Corner pixels, full-rate sink
    display = '0;
    display[0] = 1'b1; display[63] = 1'b1; display[2047] = 1'b1;
    snap = display;
    start_frame();
    stream_frame(snap, 100, 1'b0, 1'b0);
    end_frame();

    // Random image, 50% ready backpressure
    display = rand_fb();
    snap = display;
    start_frame();
    stream_frame(snap, 50, 1'b0, 1'b0);
    end_frame();

    // Display flipped mid-stream must not affect the frame
    display = rand_fb();
    snap = display;
    start_frame();
    stream_frame(snap, 100, 1'b1, 1'b0);
    end_frame();

    // Three requests during a frame -> exactly one extra frame, snapshot taken at its start
    display = rand_fb();
    snap = display;
    start_frame();
    stream_frame(snap, 100, 1'b1, 1'b1);
    end_frame();
    snap = display;
    @(posedge clk); #1;
    check("pend_start", 32'(pix_valid), 32'd1);
    stream_frame(snap, 70, 1'b0, 1'b0);
    end_frame();
    repeat (3) begin
      @(posedge clk); #1;
      check("no_third", 32'(pix_valid), 32'd0);
    end

    // Async reset mid-stream with a pending request queued
    display = rand_fb();
    start_frame();
    pix_ready = 1'b1;
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_outs", 32'({pix_valid, busy, frame_done, pix_sof, pix_eol, pix_eof}), 32'd0);
    #2;
    reset = 1'b1;
    pix_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_pend_clr", 32'({pix_valid, busy, frame_done}), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
